onchip_memory_copy_engine: RTL
==============================

# onchip_memory_copy_engine

Avalon-MM copy engine in front of the 2048 x 32 single-port on-chip memory. It copies a block of words from a source word index to a destination word index under CPU control. A CSR slave on the Nios II data bus programs source, destination and length. A master port drives the memory's second slave port, one word per three cycles, and raises an interrupt on completion.

## Interface
- `MEM_AW`, 11: memory word-address width (2048 words).
- `LEN_W`, 12: length-register width (0..2048 words).
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `csr_address` in 2: register select (0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS).
- `csr_chipselect`, `csr_read`, `csr_write` in 1: Avalon slave strobes.
- `csr_writedata` in 32: write data.
- `csr_readdata` out 32: read data, registered, read latency 1.
- `irq` out 1: level interrupt, `done & irq_en`.
- `mem_address` out `MEM_AW`: memory word address.
- `mem_byteenable` out 4: constant 4'hF.
- `mem_chipselect`, `mem_write` out 1: memory strobes.
- `mem_writedata` out 32: data to be written.
- `mem_clken` out 1: constant 1.
- `mem_readdata` in 32: memory read data, valid the cycle after the address is presented.

## Operation
- Registers:
  - SRC[10:0], DST[10:0], LEN[11:0]: read/write. Writes are ignored while busy.
  - CTRL write: bit0 start, bit1 irq_en (stored), bit2 clear done/error (write-1).
  - STATUS read: bit0 busy, bit1 done, bit2 irq_en, bit3 error. Unused bits read 0.
- FSM states: IDLE, RD, LAT, WR.
  - IDLE --start--> RD, only when LEN≠0 and no error.
  - RD --> LAT --> WR.
  - WR --> RD while remaining≠0, else --> IDLE with done=1.
- Start checks (evaluated at the start write):
  - SRC+LEN>2048 or DST+LEN>2048: no transfer; error=1, done=1.
  - LEN=0: no transfer; done=1 the next cycle, error=0.
  - Start while busy: ignored.
- At start, internal counters are loaded: rd_ptr=SRC, wr_ptr=DST, remaining=LEN. SRC/DST/LEN are not modified.
- RD: mem_chipselect=1, mem_write=0, mem_address=rd_ptr.
- LAT: data_q <= mem_readdata. No memory access.
- WR: mem_chipselect=1, mem_write=1, mem_address=wr_ptr, mem_writedata=data_q.
  - rd_ptr++, wr_ptr++, remaining--.
- Copy is always ascending. Overlapping regions with DST>SRC replicate the source prefix; this is the defined behaviour.
- The done flag is sticky until cleared. A new start clears done and error.
- Reset values:
  - All registers, counters, flags and csr_readdata = 0; state = IDLE.
  - mem_chipselect = mem_write = 0; irq = 0.
  - Reset mid-transfer aborts immediately. Memory contents already written stay written.

## Timing
- Start written at edge t: RD is active in cycle t+1, LAT in t+2, WR in t+3.
- Each word takes 3 cycles. For LEN=N, busy is high for exactly 3N cycles.
- done rises on the edge that ends the final WR; irq is asserted in the same cycle.
- CSR read issued at edge t: data presented in cycle t+1.
- A CSR write and a start in the same cycle cannot occur: single slave port, one access per cycle.
- The clear-done write wins over a same-cycle completion: done ends at 0.

## Structure
- Shared package `copy_engine_pkg`:
  - state enum;
  - CSR offsets (SRC_OFS=0, DST_OFS=1, LEN_OFS=2, CTRL_OFS=3);
  - CTRL/STATUS bit positions;
  - MEM_WORDS=2048.
- One sub-module, `copy_engine_csr`: register file, start/clear pulse generation, range check, readdata mux.
- The top level holds the FSM, counters and master port.

## Test plan
- SRC=0x010, DST=0x100, LEN=4, memory preloaded with words 0xA0..0xA3 → words 0x100..0x103 read back 0xA0..0xA3. Busy for 12 cycles. done=1; irq=1 when irq_en=1.
- LEN=0, start → no mem_chipselect pulse; STATUS=0x2 one cycle after the start write.
- SRC=0x7FE, LEN=3 → error=1, done=1; no memory access; STATUS bit3=1.
- Write DST=0x200 mid-transfer (original DST=0x100) → ignored: copy completes at 0x100; DST reads back 0x100.
- reset asserted in the 5th busy cycle of a LEN=8 copy → next cycle busy=0, mem_chipselect=0, all CSRs read 0. Only word 0 was copied.
- Overlap SRC=0x000, DST=0x001, LEN=3, mem[0]=0x55 → mem[1..3]=0x55. Then write CTRL bit2 → done=0, irq=0.

Source files
------------

// File: rtl/copy_engine_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | copy_engine_pkg: shared types and constants for the copy engine     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package copy_engine_pkg;

  localparam int MEM_WORDS = 2048;

  localparam logic [1:0] SRC_OFS  = 2'd0;
  localparam logic [1:0] DST_OFS  = 2'd1;
  localparam logic [1:0] LEN_OFS  = 2'd2;
  localparam logic [1:0] CTRL_OFS = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int CTRL_CLEAR_BIT = 2;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_IRQEN_BIT = 2;
  localparam int STAT_ERROR_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LAT  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/copy_engine_csr.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | copy_engine_csr: register file, start/clear handling, range check   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module copy_engine_csr
  import copy_engine_pkg::*;
#(
  parameter int MEM_AW = 11,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic              busy,
  input  logic              fin,
  output logic [MEM_AW-1:0] src,
  output logic [MEM_AW-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              start,
  output logic              irq
);

  localparam int SUM_W = LEN_W + 1;

  logic [MEM_AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d, error_q, error_d, irq_en_q, irq_en_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              wr_en, rd_en, ctrl_wr, start_req, in_range;
  logic [SUM_W-1:0]  src_end, dst_end;
  logic [31:0]       status;
  logic              unused_wdata;

  assign wr_en     = csr_chipselect & csr_write;
  assign rd_en     = csr_chipselect & csr_read;
  assign ctrl_wr   = wr_en && (csr_address == CTRL_OFS);
  assign start_req = ctrl_wr && csr_writedata[CTRL_START_BIT] && !busy;

  // Extra bit keeps base+length from wrapping before the bound compare.
  assign src_end  = SUM_W'(src_q) + SUM_W'(len_q);
  assign dst_end  = SUM_W'(dst_q) + SUM_W'(len_q);
  assign in_range = (src_end <= SUM_W'(MEM_WORDS)) && (dst_end <= SUM_W'(MEM_WORDS));

  assign start        = start_req && in_range && (len_q != '0);
  assign src          = src_q;
  assign dst          = dst_q;
  assign len          = len_q;
  assign irq          = done_q & irq_en_q;
  assign csr_readdata = readdata_q;
  assign unused_wdata = ^csr_writedata[31:LEN_W];

  always_comb begin
    status                 = '0;
    status[STAT_BUSY_BIT]  = busy;
    status[STAT_DONE_BIT]  = done_q;
    status[STAT_IRQEN_BIT] = irq_en_q;
    status[STAT_ERROR_BIT] = error_q;
  end

  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    done_d     = done_q;
    error_d    = error_q;
    irq_en_d   = irq_en_q;
    readdata_d = readdata_q;

    if (wr_en && !busy) begin
      case (csr_address)
        SRC_OFS: src_d = csr_writedata[MEM_AW-1:0];
        DST_OFS: dst_d = csr_writedata[MEM_AW-1:0];
        LEN_OFS: len_d = csr_writedata[LEN_W-1:0];
        default: ;
      endcase
    end

    if (fin) done_d = 1'b1;

    // Placed after completion so a same-cycle clear leaves done at 0.
    if (ctrl_wr) begin
      irq_en_d = csr_writedata[CTRL_IRQEN_BIT];
      if (csr_writedata[CTRL_CLEAR_BIT]) begin
        done_d  = 1'b0;
        error_d = 1'b0;
      end
      if (start_req) begin
        if (!in_range) begin
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          done_d  = (len_q == '0);
          error_d = 1'b0;
        end
      end
    end

    if (rd_en) begin
      case (csr_address)
        SRC_OFS: readdata_d = 32'(src_q);
        DST_OFS: readdata_d = 32'(dst_q);
        LEN_OFS: readdata_d = 32'(len_q);
        default: readdata_d = status;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      done_q     <= done_d;
      error_q    <= error_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/onchip_memory_copy_engine.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | onchip_memory_copy_engine: CSR-programmed ascending word copier     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module onchip_memory_copy_engine
  import copy_engine_pkg::*;
#(
  parameter int MEM_AW = 11,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [MEM_AW-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [31:0]       data_q, data_d;
  logic [MEM_AW-1:0] src, dst;
  logic [LEN_W-1:0]  len;
  logic              start, fin, busy;

  assign busy           = (state_q != ST_IDLE);
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign mem_writedata  = data_q;

  copy_engine_csr #(
    .MEM_AW(MEM_AW),
    .LEN_W (LEN_W)
  ) u_csr (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_chipselect(csr_chipselect),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .busy          (busy),
    .fin           (fin),
    .src           (src),
    .dst           (dst),
    .len           (len),
    .start         (start),
    .irq           (irq)
  );

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    remaining_d    = remaining_q;
    data_d         = data_q;
    fin            = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_ptr_d    = src;
          wr_ptr_d    = dst;
          remaining_d = len;
          state_d     = ST_RD;
        end
      end
      ST_RD: begin
        mem_chipselect = 1'b1;
        state_d        = ST_LAT;
      end
      ST_LAT: begin
        data_d  = mem_readdata;
        state_d = ST_WR;
      end
      ST_WR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q + MEM_AW'(1);
        wr_ptr_d       = wr_ptr_q + MEM_AW'(1);
        remaining_d    = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

endmodule
`default_nettype wire
